sram32_arbiter: RTL



---
 rtl/sram32_pkg.sv | 29 ++
 rtl/sram32_arbiter_if.sv | 16 +
 rtl/sram32_arb_sel.sv | 34 +++
 rtl/sram32_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sram32_pkg.sv
// Shared types and constants for the two-port external SRAM controller/arbiter.
package sram32_pkg;

  localparam int ADR_W = 22;
  localparam int DAT_W = 32;
  localparam int BE_W  = 4;

  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;
  localparam int TURN_DEF    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WHOLD,
    ST_TURN
  } state_e;

  // The turnaround phase shares the wait counter, so it takes part in the sizing.
  function automatic int cnt_width(input int rd, input int wr, input int turn);
    int m;
    m = rd;
    if (wr > m)   m = wr;
    if (turn > m) m = turn;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram32_arbiter_if.sv
// Single-word request/ack bundle between one on-chip master and the SRAM arbiter.
interface sram32_arbiter_if;
  import sram32_pkg::*;

  logic             req;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] wdat;
  logic [BE_W-1:0]  be;
  logic             ack;
  logic [DAT_W-1:0] rdat;

  modport master (output req, we, adr, wdat, be, input  ack, rdat);
  modport slave  (input  req, we, adr, wdat, be, output ack, rdat);

endinterface

// File: rtl/sram32_arb_sel.sv
// Combinational grant select for two requesters; round-robin tie-break under
// SRAM32_ARB_RR_EN, fixed priority to port 0 otherwise.
module sram32_arb_sel (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o,
  output logic       valid_o
);

  assign valid_o = |req_i;

`ifdef SRAM32_ARB_RR_EN
  logic last_q;

  // Resetting to port 1 hands the first tie to port 0.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (take_i) last_q <= gnt_o;
  end

  always_comb begin
    gnt_o = 1'b0;
    if (&req_i) gnt_o = ~last_q;
    else        gnt_o = ~req_i[0];
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, take_i};
  assign gnt_o     = ~req_i[0];
`endif

endmodule

// File: rtl/sram32_arbiter.sv
// Two-port controller/arbiter for a 32-bit asynchronous SRAM with programmable
// read/write wait states and read turnaround. Optional macro: SRAM32_ARB_RR_EN.
module sram32_arbiter
  import sram32_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int TURN    = TURN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sram32_arbiter_if.slave  m0,
  sram32_arbiter_if.slave  m1,
  output logic [ADR_W-1:0] sram_adr_o,
  output logic [DAT_W-1:0] sram_d_o,
  output logic             sram_d_oe_o,
  input  logic [DAT_W-1:0] sram_d_i,
  output logic             sram_ce_n_o,
  output logic             sram_oe_n_o,
  output logic             sram_we_n_o,
  output logic [BE_W-1:0]  sram_be_n_o
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT, TURN);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic [ADR_W-1:0]      adr_q, adr_d;
  logic [DAT_W-1:0]      wdat_q, wdat_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [BE_W-1:0]       be_n_q, be_n_d;
  logic                  d_oe_q, d_oe_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0][DAT_W-1:0] rdat_q;
  logic                  cap;
  logic                  take;
  logic [1:0]            req_eff;
  logic                  sel_gnt, sel_valid;

  // A port whose ack is high this cycle is still showing the finished request.
  assign req_eff = {m1.req & ~ack_q[1], m0.req & ~ack_q[0]};

  sram32_arb_sel u_sel (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_eff),
    .take_i  (take),
    .gnt_o   (sel_gnt),
    .valid_o (sel_valid)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    ack_d   = 2'b00;
    cap     = 1'b0;
    take    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          take   = 1'b1;
          gnt_d  = sel_gnt;
          adr_d  = sel_gnt ? m1.adr  : m0.adr;
          wdat_d = sel_gnt ? m1.wdat : m0.wdat;
          be_d   = sel_gnt ? m1.be   : m0.be;
          if (sel_gnt ? m1.we : m0.we) begin
            state_d = ST_WRITE;
            cnt_d   = CNT_W'(WR_WAIT - 1);
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          cap          = 1'b1;
          ack_d[gnt_q] = 1'b1;
          if (TURN > 0) begin
            state_d = ST_TURN;
            cnt_d   = CNT_W'(TURN - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d      = ST_WHOLD;
          ack_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WHOLD: state_d = ST_IDLE;
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so the pins come straight off flops.
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    be_n_d = '1;
    d_oe_d = 1'b0;
    unique case (state_d)
      ST_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      ST_WRITE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        be_n_d = ~be_d;
        d_oe_d = 1'b1;
      end
      ST_WHOLD: begin
        ce_n_d = 1'b0;
        be_n_d = ~be_d;
        d_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      be_q    <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      d_oe_q  <= 1'b0;
      ack_q   <= 2'b00;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      d_oe_q  <= d_oe_d;
      ack_q   <= ack_d;
      if (cap) rdat_q[gnt_q] <= sram_d_i;
    end
  end

  assign sram_adr_o  = adr_q;
  assign sram_d_o    = wdat_q;
  assign sram_d_oe_o = d_oe_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_be_n_o = be_n_q;

  assign m0.ack  = ack_q[0];
  assign m1.ack  = ack_q[1];
  assign m0.rdat = rdat_q[0];
  assign m1.rdat = rdat_q[1];

endmodule
